// File: rtl/mdu_e_stage.sv
// E-stage multiply/divide unit: architectural HI/LO, multi-cycle mult/div with Busy, mthi/mtlo.
// Optional madd/maddu/msub/msubu (MDUOp 7..10) enabled by defining MDU_MADD_EN.
module mdu_e_stage #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic        RdSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] O
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [1:0] MODE_SET  = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_SUB  = 2'd2;
  localparam logic [1:0] MODE_NONE = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] shd_q, shd_d;
  logic [1:0]  mode_q, mode_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, mag_a, mag_b, uq, ur, sq_mag, sr_mag;
  logic [31:0] quo_u, rem_u, quo_s, rem_s;
  logic [63:0] hilo_s;

  // Arithmetic datapath; divisor forced non-zero so no X escapes when dividing by 0.
  always_comb begin
    prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
    prod_u = {32'd0, A1} * {32'd0, A2};
    div_b  = (A2 == 32'd0) ? 32'd1 : A2;
    quo_u  = A1 / div_b;
    rem_u  = A1 % div_b;
    mag_a  = A1[31] ? (32'd0 - A1) : A1;
    mag_b  = div_b[31] ? (32'd0 - div_b) : div_b;
    uq     = mag_a / mag_b;
    ur     = mag_a % mag_b;
    sq_mag = (A1[31] ^ div_b[31]) ? (32'd0 - uq) : uq;
    sr_mag = A1[31] ? (32'd0 - ur) : ur;
    quo_s  = sq_mag;
    rem_s  = sr_mag;
    hilo_s = {hi_q, lo_q};
  end

  // Next-state logic: issue in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shd_d   = shd_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            4'd1: begin shd_d = prod_s; mode_d = MODE_SET; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
            4'd2: begin shd_d = prod_u; mode_d = MODE_SET; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
            4'd3: begin
              shd_d   = {rem_s, quo_s};
              mode_d  = (A2 == 32'd0) ? MODE_NONE : MODE_SET;
              cnt_d   = 8'(DIV_CYCLES);
              state_d = RUN;
            end
            4'd4: begin
              shd_d   = {rem_u, quo_u};
              mode_d  = (A2 == 32'd0) ? MODE_NONE : MODE_SET;
              cnt_d   = 8'(DIV_CYCLES);
              state_d = RUN;
            end
            4'd5: hi_d = A1;
            4'd6: lo_d = A1;
`ifdef MDU_MADD_EN
            4'd7:  begin shd_d = prod_s; mode_d = MODE_ADD; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
            4'd8:  begin shd_d = prod_u; mode_d = MODE_ADD; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
            4'd9:  begin shd_d = prod_s; mode_d = MODE_SUB; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
            4'd10: begin shd_d = prod_u; mode_d = MODE_SUB; cnt_d = 8'(MULT_CYCLES); state_d = RUN; end
`endif
            default: ;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 8'd1;
        // Accumulating ops read {HI,LO} here, at commit, not at issue.
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
          case (mode_q)
            MODE_SET: {hi_d, lo_d} = shd_q;
            MODE_ADD: {hi_d, lo_d} = hilo_s + shd_q;
            MODE_SUB: {hi_d, lo_d} = hilo_s - shd_q;
            default:  ;
          endcase
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      shd_q   <= 64'd0;
      mode_q  <= MODE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shd_q   <= shd_d;
      mode_q  <= mode_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign O    = RdSel ? hi_q : lo_q;

endmodule
